// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/MDU side and wb_port_arbiter.
// master = pipeline, MDU and decode side; slave = the arbiter.
interface wb_port_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        pend_rs;
  logic        pend_rt;
  logic        pend_issue;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs, rt,
    input  mdu_ready, pend_rs, pend_rt, pend_issue, wb_hold, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs, rt,
    output mdu_ready, pend_rs, pend_rt, pend_issue, wb_hold, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results.
// Optional starvation guard: define WB_STARVE_GUARD_EN to build the hold FSM.
//
// state | meaning
// RUN   | pipeline has priority; count cycles the buffer head waits
// HOLD  | wb_hold asserted; the MDU head owns this write slot
module wb_port_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = BUF_DEPTH[PTR_W:0];

  logic [4:0]       rdMem   [BUF_DEPTH];
  logic [31:0]      dataMem [BUF_DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W:0]   count;

  logic [31:1] busy;
  logic [31:0] busyVec;
  logic [31:0] busyNext;

  logic        wbHold;
  logic        pipeGrant;
  logic        bufEmpty;
  logic        push;
  logic        pop;
  logic [4:0]  headRd;

  logic        rfWe;
  logic [4:0]  rfWa;
  logic [31:0] rfWd;

  assign busyVec   = {busy, 1'b0};
  assign bufEmpty  = (count == '0);
  assign pipeGrant = bus.wb_valid && !wbHold && (bus.wb_rd != 5'd0);
  assign pop       = !pipeGrant && !bufEmpty;
  assign push      = bus.mdu_valid && bus.mdu_ready;
  assign headRd    = rdMem[headPtr];

  assign bus.mdu_ready  = (count != FULL_CNT);
  assign bus.pend_rs    = busyVec[bus.rs];
  assign bus.pend_rt    = busyVec[bus.rt];
  assign bus.pend_issue = busyVec[bus.issue_rd];
  assign bus.wb_hold    = wbHold;
  assign bus.rf_we      = rfWe;
  assign bus.rf_wa      = rfWa;
  assign bus.rf_wd      = rfWd;

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[tailPtr]   <= bus.mdu_rd;
      dataMem[tailPtr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PTR_W'(1);
      if (pop)  headPtr <= headPtr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rfWe <= 1'b0;
      rfWa <= '0;
      rfWd <= '0;
    end else if (pipeGrant) begin
      rfWe <= 1'b1;
      rfWa <= bus.wb_rd;
      rfWd <= bus.wb_data;
    end else if (pop) begin
      rfWe <= 1'b1;
      rfWa <= headRd;
      rfWd <= dataMem[headPtr];
    end else begin
      rfWe <= 1'b0;
    end
  end

  // A new issue to the register being retired must stay pending, so set follows clear.
  always_comb begin
    busyNext = busyVec;
    if (pop) busyNext[headRd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) busyNext[bus.issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busyNext[31:1];
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] starveCnt;
  logic [CNT_W-1:0] starveNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveNext;
    end
  end

  always_comb begin
    stateNext  = state;
    starveNext = '0;
    case (state)
      RUN: begin
        if (!bufEmpty && !pop) begin
          if (starveCnt == CNT_LAST) stateNext = HOLD;
          else                       starveNext = starveCnt + CNT_W'(1);
        end
      end
      HOLD:    stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign wbHold = (state == HOLD);
`else
  assign wbHold = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
// Expectations around the starvation hold follow WB_STARVE_GUARD_EN.
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    checkVal({tag, "_we"}, 32'(bus.rf_we), 32'(we));
    checkVal({tag, "_wa"}, 32'(bus.rf_wa), 32'(wa));
    checkVal({tag, "_wd"}, bus.rf_wd, wd);
  endtask

  initial begin
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.rs = 5; bus.rt = 6;

    // reset then idle
    tick(); tick();
    reset = 1'b0;
    tick();
    checkRf("rst", 1'b0, 5'd0, 32'h0);
    checkVal("rst_ready", 32'(bus.mdu_ready), 32'd1);
    checkVal("rst_hold", 32'(bus.wb_hold), 32'd0);
    checkVal("rst_pend_rs", 32'(bus.pend_rs), 32'd0);
    checkVal("rst_pend_rt", 32'(bus.pend_rt), 32'd0);
    checkVal("rst_pend_issue", 32'(bus.pend_issue), 32'd0);

    // plain pipeline write, then rd=0 slot
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
    tick();
    checkRf("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
    bus.wb_rd = 0; bus.wb_data = 32'h1;
    tick();
    checkRf("pipe_rd0", 1'b0, 5'd5, 32'hDEADBEEF);
    bus.wb_valid = 0;

    // scoreboard round trip for rd=7
    bus.rs = 7; bus.issue_valid = 1; bus.issue_rd = 7;
    checkVal("pend_pre_issue", 32'(bus.pend_rs), 32'd0);
    tick();
    bus.issue_valid = 0;
    checkVal("pend_rs7_set", 32'(bus.pend_rs), 32'd1);
    checkVal("pend_issue7", 32'(bus.pend_issue), 32'd1);
    tick(); tick();
    checkVal("pend_rs7_wait", 32'(bus.pend_rs), 32'd1);
    bus.mdu_valid = 1; bus.mdu_rd = 7; bus.mdu_data = 32'h12;
    checkVal("ready_rd7", 32'(bus.mdu_ready), 32'd1);
    tick();
    bus.mdu_valid = 0;
    checkVal("pend_rs7_pushed", 32'(bus.pend_rs), 32'd1);
    checkVal("mdu_no_bypass_we", 32'(bus.rf_we), 32'd0);
    tick();
    checkRf("mdu_rd7", 1'b1, 5'd7, 32'h12);
    checkVal("pend_rs7_clear", 32'(bus.pend_rs), 32'd0);
    tick();
    checkVal("idle_we", 32'(bus.rf_we), 32'd0);

    // pipeline busy every cycle; two MDU results wait
    bus.wb_valid = 1; bus.wb_rd = 10; bus.wb_data = 32'h200;
    bus.mdu_valid = 1; bus.mdu_rd = 11; bus.mdu_data = 32'hA1;
    tick();
    checkVal("ready_one", 32'(bus.mdu_ready), 32'd1);
    checkRf("busy0", 1'b1, 5'd10, 32'h200);
    bus.wb_data = 32'h201; bus.mdu_rd = 12; bus.mdu_data = 32'hA2;
    tick();
    bus.mdu_valid = 0;
    checkVal("ready_full", 32'(bus.mdu_ready), 32'd0);
    checkVal("hold_1", 32'(bus.wb_hold), 32'd0);
    checkRf("busy1", 1'b1, 5'd10, 32'h201);
    for (int k = 2; k <= 8; k++) begin
      bus.wb_data = 32'h200 + 32'(k);
      tick();
      checkVal($sformatf("starve_wd_%0d", k), bus.rf_wd, 32'h200 + 32'(k));
      checkVal($sformatf("starve_hold_%0d", k), 32'(bus.wb_hold), 32'(GUARD && (k == 8)));
      checkVal($sformatf("starve_ready_%0d", k), 32'(bus.mdu_ready), 32'd0);
    end
    bus.wb_data = 32'h209;
    tick();
    checkRf("held_slot", 1'b1, GUARD ? 5'd11 : 5'd10, GUARD ? 32'hA1 : 32'h209);
    checkVal("held_release", 32'(bus.wb_hold), 32'd0);
    checkVal("held_ready", 32'(bus.mdu_ready), 32'(GUARD));
    bus.wb_valid = GUARD;
    tick();
    checkRf("after_hold", 1'b1, GUARD ? 5'd10 : 5'd11, GUARD ? 32'h209 : 32'hA1);
    bus.wb_valid = 0;
    tick();
    checkRf("drain_a2", 1'b1, 5'd12, 32'hA2);
    checkVal("drain_ready", 32'(bus.mdu_ready), 32'd1);

    // same-edge set and clear of rd=9: set wins
    bus.rs = 9; bus.issue_valid = 1; bus.issue_rd = 9;
    tick();
    bus.issue_valid = 0;
    bus.mdu_valid = 1; bus.mdu_rd = 9; bus.mdu_data = 32'h99;
    tick();
    bus.mdu_valid = 0;
    bus.issue_valid = 1;
    tick();
    bus.issue_valid = 0;
    checkRf("pop_rd9", 1'b1, 5'd9, 32'h99);
    checkVal("busy9_kept", 32'(bus.pend_rs), 32'd1);
    bus.mdu_valid = 1; bus.mdu_data = 32'h9A;
    tick();
    bus.mdu_valid = 0;
    tick();
    checkRf("pop_rd9b", 1'b1, 5'd9, 32'h9A);
    checkVal("busy9_clear", 32'(bus.pend_rs), 32'd0);

    // reset while entries are buffered and rd=3 is pending
    bus.rs = 3; bus.rt = 3; bus.issue_valid = 1; bus.issue_rd = 3;
    bus.wb_valid = 1; bus.wb_rd = 4; bus.wb_data = 32'h44;
    bus.mdu_valid = 1; bus.mdu_rd = 20; bus.mdu_data = 32'h20;
    tick();
    bus.issue_valid = 0;
    bus.mdu_rd = 21; bus.mdu_data = 32'h21;
    tick();
    bus.mdu_valid = 0;
    checkVal("pre_rst_ready", 32'(bus.mdu_ready), 32'd0);
    checkVal("pre_rst_pend_rt", 32'(bus.pend_rt), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.wb_valid = 0;
    checkRf("mid_rst", 1'b0, 5'd0, 32'h0);
    checkVal("mid_rst_ready", 32'(bus.mdu_ready), 32'd1);
    checkVal("mid_rst_pend_rs", 32'(bus.pend_rs), 32'd0);
    checkVal("mid_rst_hold", 32'(bus.wb_hold), 32'd0);
    tick();
    checkVal("post_rst_we", 32'(bus.rf_we), 32'd0);
    checkVal("post_rst_pend_issue", 32'(bus.pend_issue), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
